// File: rtl/sram_arbiter.sv
// Arbitrates the single unified SRAM port between instruction fetch and the MEM stage.
// One access in flight; data has priority, with a starvation cap that eventually forces a fetch.
module sram_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  inst_req_i,
  input  logic [ADDR_WIDTH-1:0] inst_addr_i,
  output logic                  inst_ready_o,
  output logic                  inst_rvalid_o,
  output logic [DATA_WIDTH-1:0] inst_rdata_o,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_sel_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_ready_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  sram_ce_o,
  output logic                  sram_we_o,
  output logic [3:0]            sram_be_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic                  stall_if_o,
  output logic                  stall_mem_o
);

  localparam int CNT_W = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);
  localparam int STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic [STV_W-1:0] starve_q, starve_d;

  logic can_issue, resp_cycle, inst_first, grant_data, grant_inst, issue_read;

  // Outputs are gated by rst so they fall to zero the moment reset asserts.
  assign can_issue  = rst & ((state_q == IDLE) | (cnt_q == CNT_ONE));
  assign resp_cycle = rst & (state_q == RD_WAIT) & (cnt_q == CNT_ONE);
  assign inst_first = inst_req_i & (starve_q == STV_MAX);
  assign grant_data = can_issue & data_req_i & ~inst_first;
  assign grant_inst = can_issue & inst_req_i & ~grant_data;
  assign issue_read = grant_inst | (grant_data & ~data_we_i);

  assign inst_ready_o  = grant_inst;
  assign data_ready_o  = grant_data;
  assign inst_rvalid_o = resp_cycle & (owner_q == OWN_INST) & ~drop_q & ~flush_i;
  assign data_rvalid_o = resp_cycle & (owner_q == OWN_DATA);
  assign inst_rdata_o  = sram_rdata_i;
  assign data_rdata_o  = sram_rdata_i;
  assign stall_if_o    = rst & inst_req_i & ~grant_inst;
  assign stall_mem_o   = rst & ((data_req_i & ~grant_data) |
                                ((state_q == RD_WAIT) & (owner_q == OWN_DATA) & (cnt_q != CNT_ONE)));

  always_comb begin
    sram_ce_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_be_o    = 4'h0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (grant_data) begin
      sram_ce_o    = 1'b1;
      sram_we_o    = data_we_i;
      sram_be_o    = data_we_i ? data_sel_i : 4'hF;
      sram_addr_o  = data_addr_i;
      sram_wdata_o = data_wdata_i;
    end else if (grant_inst) begin
      sram_ce_o   = 1'b1;
      sram_be_o   = 4'hF;
      sram_addr_o = inst_addr_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    starve_d = starve_q;
    if (state_q == RD_WAIT) begin
      if (cnt_q == CNT_ONE) begin
        state_d = IDLE;
        cnt_d   = '0;
        drop_d  = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
        if ((owner_q == OWN_INST) && flush_i) drop_d = 1'b1;
      end
    end
    // A new read issued in the response cycle overrides the return to IDLE.
    if (issue_read) begin
      state_d = RD_WAIT;
      cnt_d   = CNT_LOAD;
      owner_d = grant_inst ? OWN_INST : OWN_DATA;
      drop_d  = 1'b0;
    end
    if (!inst_req_i || grant_inst)
      starve_d = '0;
    else if (grant_data && (starve_q != STV_MAX))
      starve_d = starve_q + STV_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_INST;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus a randomized run against a timestamp-based
// transaction model of the arbitration rules, with a latency-accurate SRAM model.
module tb_sram_arbiter;
  localparam int AW = 32, DW = 32, RD_LAT = 2, STARVE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i, inst_req_i, data_req_i, data_we_i;
  logic [3:0]    data_sel_i;
  logic [AW-1:0] inst_addr_i, data_addr_i;
  logic [DW-1:0] data_wdata_i;
  logic          inst_ready_o, inst_rvalid_o, data_ready_o, data_rvalid_o;
  logic [DW-1:0] inst_rdata_o, data_rdata_o, sram_wdata_o, sram_rdata_i;
  logic          sram_ce_o, sram_we_o, stall_if_o, stall_mem_o;
  logic [3:0]    sram_be_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] rd_pipe [RD_LAT];

  int checks = 0;
  int passes = 0;

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RD_LAT), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_ready_o(inst_ready_o),
    .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_ready_o(data_ready_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .sram_ce_o(sram_ce_o), .sram_we_o(sram_we_o), .sram_be_o(sram_be_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // SRAM: read data appears RD_LAT cycles after the issue cycle.
  always @(posedge clk) begin
    rd_pipe[0] <= (sram_ce_o && !sram_we_o) ? mem_val(sram_addr_o) : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rdata_i = rd_pipe[RD_LAT-1];

  task automatic set_idle();
    flush_i = 0; inst_req_i = 0; data_req_i = 0; data_we_i = 0;
    data_sel_i = 0; inst_addr_i = 0; data_addr_i = 0; data_wdata_i = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    next_cyc(); rst = 0; set_idle();
    next_cyc(); next_cyc(); rst = 1;
  endtask

  task automatic test_reset();
    next_cyc(); rst = 0; inst_req_i = 1; data_req_i = 1; data_we_i = 1; data_sel_i = 4'hF;
    @(negedge clk);
    checks++; if ({inst_ready_o, data_ready_o, inst_rvalid_o, data_rvalid_o, sram_ce_o, sram_we_o,
                   stall_if_o, stall_mem_o, sram_be_o} !== 12'h000)
      $display("FAIL reset_outputs got=%h exp=000", {inst_ready_o, data_ready_o, inst_rvalid_o,
               data_rvalid_o, sram_ce_o, sram_we_o, stall_if_o, stall_mem_o, sram_be_o});
    else passes++;
    set_idle(); next_cyc(); rst = 1;
  endtask

  task automatic test_solo_fetch();
    do_reset();
    next_cyc(); inst_req_i = 1; inst_addr_i = 32'h1C00_0000;
    @(negedge clk);
    checks++; if ({inst_ready_o, sram_ce_o, sram_we_o, sram_be_o, stall_if_o} !== 8'b1_1_0_1111_0)
      $display("FAIL solo_issue got=%b exp=11011110", {inst_ready_o, sram_ce_o, sram_we_o, sram_be_o, stall_if_o});
    else passes++;
    checks++; if (sram_addr_o !== 32'h1C00_0000) $display("FAIL solo_addr got=%h exp=1c000000", sram_addr_o);
    else passes++;
    next_cyc(); inst_req_i = 0; @(negedge clk);
    checks++; if (inst_rvalid_o !== 1'b0) $display("FAIL solo_early_rvalid got=%b exp=0", inst_rvalid_o);
    else passes++;
    next_cyc(); @(negedge clk);
    checks++; if ({inst_rvalid_o, inst_rdata_o} !== {1'b1, mem_val(32'h1C00_0000)})
      $display("FAIL solo_resp got=%b/%h exp=1/%h", inst_rvalid_o, inst_rdata_o, mem_val(32'h1C00_0000));
    else passes++;
  endtask

  task automatic test_collision();
    do_reset();
    next_cyc(); inst_req_i = 1; inst_addr_i = 32'h200; data_req_i = 1; data_addr_i = 32'h100;
    @(negedge clk);
    checks++; if ({data_ready_o, inst_ready_o, stall_if_o, sram_addr_o} !== {3'b101, 32'h100})
      $display("FAIL coll_t0 got=%b/%h exp=101/100", {data_ready_o, inst_ready_o, stall_if_o}, sram_addr_o);
    else passes++;
    next_cyc(); data_req_i = 0; @(negedge clk);
    checks++; if ({inst_ready_o, stall_if_o, stall_mem_o} !== 3'b011)
      $display("FAIL coll_t1 got=%b exp=011", {inst_ready_o, stall_if_o, stall_mem_o});
    else passes++;
    next_cyc(); @(negedge clk);
    checks++; if ({data_rvalid_o, data_rdata_o, inst_ready_o, stall_mem_o, sram_addr_o} !==
                  {1'b1, mem_val(32'h100), 2'b10, 32'h200})
      $display("FAIL coll_t2 got=%b/%h/%b%b/%h exp=1/%h/10/200", data_rvalid_o, data_rdata_o,
               inst_ready_o, stall_mem_o, sram_addr_o, mem_val(32'h100));
    else passes++;
    next_cyc(); inst_req_i = 0; next_cyc(); @(negedge clk);
    checks++; if ({inst_rvalid_o, inst_rdata_o} !== {1'b1, mem_val(32'h200)})
      $display("FAIL coll_inst_resp got=%b/%h exp=1/%h", inst_rvalid_o, inst_rdata_o, mem_val(32'h200));
    else passes++;
  endtask

  task automatic test_starvation();
    logic [1:0] exp_rdy;
    do_reset();
    next_cyc(); inst_req_i = 1; inst_addr_i = 32'h40; data_req_i = 1; data_addr_i = 32'h80;
    // Slots every RD_LAT cycles: four data grants, one inst grant, then data again.
    for (int c = 0; c < 6 * RD_LAT; c++) begin
      @(negedge clk);
      exp_rdy = 2'b00;
      if (c % RD_LAT == 0) exp_rdy = ((c / RD_LAT) % (STARVE + 1) == STARVE) ? 2'b10 : 2'b01;
      checks++; if ({inst_ready_o, data_ready_o} !== exp_rdy)
        $display("FAIL starve_c%0d got=%b exp=%b", c, {inst_ready_o, data_ready_o}, exp_rdy);
      else passes++;
      next_cyc();
    end
    set_idle();
  endtask

  task automatic test_store();
    do_reset();
    next_cyc(); data_req_i = 1; data_we_i = 1; data_sel_i = 4'b0011; data_addr_i = 32'h8;
    data_wdata_i = 32'hDEAD_BEEF; @(negedge clk);
    checks++; if ({data_ready_o, sram_ce_o, sram_we_o, sram_be_o, stall_mem_o} !== 8'b1_1_1_0011_0)
      $display("FAIL store_ctrl got=%b exp=11100110", {data_ready_o, sram_ce_o, sram_we_o, sram_be_o, stall_mem_o});
    else passes++;
    checks++; if ({sram_addr_o, sram_wdata_o} !== {32'h8, 32'hDEAD_BEEF})
      $display("FAIL store_bus got=%h/%h exp=8/deadbeef", sram_addr_o, sram_wdata_o);
    else passes++;
    next_cyc(); set_idle(); inst_req_i = 1; inst_addr_i = 32'h44; @(negedge clk);
    checks++; if ({inst_ready_o, data_rvalid_o} !== 2'b10)
      $display("FAIL store_next got=%b exp=10", {inst_ready_o, data_rvalid_o});
    else passes++;
    next_cyc(); inst_req_i = 0; @(negedge clk);
    checks++; if (data_rvalid_o !== 1'b0) $display("FAIL store_no_rvalid got=%b exp=0", data_rvalid_o);
    else passes++;
    next_cyc();
  endtask

  task automatic test_flush();
    do_reset();
    next_cyc(); inst_req_i = 1; inst_addr_i = 32'h300;
    next_cyc(); inst_req_i = 0; flush_i = 1;
    next_cyc(); flush_i = 0; inst_req_i = 1; inst_addr_i = 32'h304; @(negedge clk);
    checks++; if ({inst_rvalid_o, inst_ready_o} !== 2'b01)
      $display("FAIL flush_t2 got=%b exp=01", {inst_rvalid_o, inst_ready_o});
    else passes++;
    next_cyc(); inst_req_i = 0; next_cyc(); @(negedge clk);
    checks++; if ({inst_rvalid_o, inst_rdata_o} !== {1'b1, mem_val(32'h304)})
      $display("FAIL flush_refetch got=%b/%h exp=1/%h", inst_rvalid_o, inst_rdata_o, mem_val(32'h304));
    else passes++;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    next_cyc(); data_req_i = 1; data_addr_i = 32'h500;
    next_cyc(); data_req_i = 0; rst = 0; @(negedge clk);
    checks++; if ({data_ready_o, data_rvalid_o, sram_ce_o, sram_be_o, stall_mem_o} !== 8'h00)
      $display("FAIL midrst_outputs got=%b exp=00000000", {data_ready_o, data_rvalid_o, sram_ce_o, sram_be_o, stall_mem_o});
    else passes++;
    next_cyc(); rst = 1; @(negedge clk);
    checks++; if (data_rvalid_o !== 1'b0) $display("FAIL midrst_rvalid got=%b exp=0", data_rvalid_o);
    else passes++;
    next_cyc(); data_req_i = 1; data_addr_i = 32'h600; @(negedge clk);
    checks++; if (data_ready_o !== 1'b1) $display("FAIL midrst_reissue got=%b exp=1", data_ready_o);
    else passes++;
    next_cyc(); set_idle(); next_cyc(); @(negedge clk);
    checks++; if ({data_rvalid_o, data_rdata_o} !== {1'b1, mem_val(32'h600)})
      $display("FAIL midrst_resp got=%b/%h exp=1/%h", data_rvalid_o, data_rdata_o, mem_val(32'h600));
    else passes++;
  endtask

  // Model: time-stamped pending read, earliest next issue cycle, and a starvation count.
  task automatic test_random(input int ncyc);
    int next_issue = 0, starve = 0, pdue = 0;
    bit pv = 0, pdata = 0, pdrop = 0, hold_i = 0, hold_d = 0;
    bit resp_now, can, gd, gi;
    logic [AW-1:0] paddr = '0;
    logic [6:0] exp_v, got_v;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      next_cyc();
      if (!hold_i) begin inst_req_i = ($urandom % 3) == 0; inst_addr_i = $urandom & ~32'h3; end
      if (!hold_d) begin
        data_req_i = ($urandom % 3) == 0; data_we_i = ($urandom % 3) == 0;
        data_sel_i = 4'($urandom); data_addr_i = $urandom & ~32'h3; data_wdata_i = $urandom;
      end
      flush_i = ($urandom % 5) == 0;
      @(negedge clk);
      resp_now = pv && (pdue == c);
      can = c >= next_issue;
      gd = can && data_req_i && !(inst_req_i && starve == STARVE);
      gi = can && inst_req_i && !gd;
      exp_v = {gi, gd, gi || gd, inst_req_i && !gi,
               (data_req_i && !gd) || (pv && pdata && !resp_now),
               resp_now && !pdata && !pdrop && !flush_i, resp_now && pdata};
      got_v = {inst_ready_o, data_ready_o, sram_ce_o, stall_if_o, stall_mem_o, inst_rvalid_o, data_rvalid_o};
      checks++; if (got_v !== exp_v) $display("FAIL rand_ctrl c=%0d got=%b exp=%b", c, got_v, exp_v);
      else passes++;
      if (gd) begin
        checks++; if ({sram_we_o, sram_be_o, sram_addr_o} !== {data_we_i, data_we_i ? data_sel_i : 4'hF, data_addr_i}
                      || (data_we_i && sram_wdata_o !== data_wdata_i))
          $display("FAIL rand_dbus c=%0d got=%b/%h/%h/%h", c, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o);
        else passes++;
      end
      if (gi) begin
        checks++; if ({sram_we_o, sram_be_o, sram_addr_o} !== {1'b0, 4'hF, inst_addr_i})
          $display("FAIL rand_ibus c=%0d got=%b/%h/%h exp=0/f/%h", c, sram_we_o, sram_be_o, sram_addr_o, inst_addr_i);
        else passes++;
      end
      if (resp_now && (pdata || (!pdrop && !flush_i))) begin
        checks++; if ((pdata ? data_rdata_o : inst_rdata_o) !== mem_val(paddr))
          $display("FAIL rand_rdata c=%0d got=%h exp=%h", c, pdata ? data_rdata_o : inst_rdata_o, mem_val(paddr));
        else passes++;
      end
      if (pv && !resp_now && !pdata && flush_i) pdrop = 1;
      if (resp_now) pv = 0;
      if (gi || (gd && !data_we_i)) begin
        pv = 1; pdata = gd; pdrop = 0; pdue = c + RD_LAT; next_issue = c + RD_LAT;
        paddr = gd ? data_addr_i : inst_addr_i;
      end
      if (!inst_req_i || gi) starve = 0;
      else if (gd && starve < STARVE) starve++;
      hold_i = inst_req_i && !gi;
      hold_d = data_req_i && !gd;
    end
    next_cyc(); set_idle();
  endtask

  initial begin
    rst = 1;
    set_idle();
    test_reset();
    test_solo_fetch();
    test_collision();
    test_starvation();
    test_store();
    test_flush();
    test_reset_mid_read();
    test_random(600);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
